// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and width helpers for the I-cache refill controller.
package FetchUnitTypes;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        REQ,
        FILL,
        WRITE
    } refillState_e;

    // Widths for the default geometry; parameterised instances use the helpers below.
    localparam int OFFSET_BITS = 4;
    localparam int INDEX_BITS  = 8;
    localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int BEAT_BITS   = 32;
    localparam int LINE_BITS   = 128;

    function automatic int calcTagBits(input int addrWidth, input int lineBytes, input int setNum);
        return addrWidth - $clog2(setNum) - $clog2(lineBytes);
    endfunction

    function automatic int calcBeats(input int lineBytes, input int beatBytes);
        return lineBytes / beatBytes;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Memory read port and tag/data array write port of the refill controller.
interface icache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int BEAT_BYTES = 4,
    parameter int SET_NUM    = 256,
    parameter int WAY_NUM    = 2
);
    import FetchUnitTypes::*;

    localparam int IDX_W  = $clog2(SET_NUM);
    localparam int WAY_W  = $clog2(WAY_NUM);
    localparam int TAG_W  = calcTagBits(ADDR_WIDTH, LINE_BYTES, SET_NUM);

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic                    mem_rvalid;
    logic [BEAT_BYTES*8-1:0] mem_rdata;

    logic                    array_we;
    logic [IDX_W-1:0]        array_index;
    logic [WAY_W-1:0]        array_way;
    logic [TAG_W-1:0]        array_tag;
    logic                    array_valid;
    logic [LINE_BYTES*8-1:0] array_data;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output array_we, array_index, array_way, array_tag, array_valid, array_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  array_we, array_index, array_way, array_tag, array_valid, array_data
    );

endinterface

// File: rtl/icache_refill_line_buffer.sv
// Beat counter and line assembly register; beat k lands in slot k.
module icache_refill_line_buffer #(
    parameter int BEATS     = 4,
    parameter int BEAT_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       beatValid,
    input  logic [BEAT_BITS-1:0]       beatData,
    output logic [BEATS*BEAT_BITS-1:0] lineData,
    output logic                       lastBeat
);

    localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_BITS-1:0] countReg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            countReg <= '0;
        end else if (beatValid) begin
            countReg <= countReg + 1'b1;
        end
    end

    assign lastBeat = (countReg == CNT_BITS'(BEATS - 1));

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : gSlot
            logic [BEAT_BITS-1:0] slotReg;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    slotReg <= '0;
                end else if (beatValid && (countReg == CNT_BITS'(gi))) begin
                    slotReg <= beatData;
                end
            end

            assign lineData[gi*BEAT_BITS +: BEAT_BITS] = slotReg;
        end
    endgenerate

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill sequencer: post-reset invalidate sweep, line read, array write.
module icache_refill_ctrl
    import FetchUnitTypes::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int BEAT_BYTES = 4,
    parameter int SET_NUM    = 256,
    parameter int WAY_NUM    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  flush,
    output logic                  busy,
    output logic                  fill_done,
    icache_refill_ctrl_if.master  bus
);

    localparam int OFF_BITS  = $clog2(LINE_BYTES);
    localparam int IDX_BITS  = $clog2(SET_NUM);
    localparam int WAY_BITS  = $clog2(WAY_NUM);
    localparam int BEATS     = calcBeats(LINE_BYTES, BEAT_BYTES);
    localparam int BT_BITS   = BEAT_BYTES * 8;
    localparam int LN_BITS   = LINE_BYTES * 8;
    localparam int INIT_BITS = IDX_BITS + WAY_BITS;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

    refillState_e           stateReg, stateNext;
    logic [INIT_BITS-1:0]   initCountReg;
    logic [WAY_BITS-1:0]    victimReg;
    logic                   abortReg;
    logic [ADDR_WIDTH-1:0]  lineAddrReg;

    logic                   missAccept;
    logic                   reqFire;
    logic                   beatValid;
    logic                   lastBeat;
    logic [LN_BITS-1:0]     lineData;

    assign missAccept = (stateReg == IDLE) && miss_valid && !flush;
    assign reqFire    = (stateReg == REQ) && bus.mem_req_ready;
    assign beatValid  = (stateReg == FILL) && bus.mem_rvalid;

    icache_refill_line_buffer #(
        .BEATS     (BEATS),
        .BEAT_BITS (BT_BITS)
    ) lineBuffer (
        .clk       (clk),
        .rst       (rst),
        .clear     (reqFire),
        .beatValid (beatValid),
        .beatData  (bus.mem_rdata),
        .lineData  (lineData),
        .lastBeat  (lastBeat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= INIT;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            INIT:    if (&initCountReg) stateNext = IDLE;
            IDLE:    if (missAccept) stateNext = REQ;
            REQ:     if (bus.mem_req_ready) stateNext = FILL;
            FILL:    if (beatValid && lastBeat) stateNext = WRITE;
            WRITE:   stateNext = IDLE;
            default: stateNext = INIT;
        endcase
    end

    // Sweep counter is {way, set}, so all sets of way 0 are cleared first.
    always_ff @(posedge clk) begin
        if (rst) begin
            initCountReg <= '0;
            victimReg    <= '0;
            abortReg     <= 1'b0;
            lineAddrReg  <= '0;
        end else begin
            if (stateReg == INIT) begin
                initCountReg <= initCountReg + 1'b1;
            end
            if (stateReg == WRITE) begin
                victimReg <= victimReg + 1'b1;
            end
            if (missAccept) begin
                abortReg    <= 1'b0;
                lineAddrReg <= miss_addr & ALIGN_MASK;
            end else if (flush && (stateReg == REQ || stateReg == FILL || stateReg == WRITE)) begin
                abortReg <= 1'b1;
            end
        end
    end

    // An aborted refill still writes its line; only the completion pulse is withheld.
    always_comb begin
        busy              = (stateReg != IDLE);
        fill_done         = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = lineAddrReg;
        bus.array_we      = 1'b0;
        bus.array_valid   = 1'b0;
        bus.array_index   = '0;
        bus.array_way     = '0;
        bus.array_tag     = '0;
        bus.array_data    = '0;
        case (stateReg)
            INIT: begin
                bus.array_we    = 1'b1;
                bus.array_index = initCountReg[IDX_BITS-1:0];
                bus.array_way   = initCountReg[INIT_BITS-1:IDX_BITS];
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
            end
            WRITE: begin
                bus.array_we    = 1'b1;
                bus.array_valid = 1'b1;
                bus.array_index = lineAddrReg[OFF_BITS+IDX_BITS-1:OFF_BITS];
                bus.array_way   = victimReg;
                bus.array_tag   = lineAddrReg[ADDR_WIDTH-1:OFF_BITS+IDX_BITS];
                bus.array_data  = lineData;
                fill_done       = !abortReg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a scoreboard of expected array writes.
module tb_icache_refill_ctrl;

    localparam int AW    = 32;
    localparam int LB    = 16;
    localparam int BB    = 4;
    localparam int SN    = 4;
    localparam int WN    = 2;
    localparam int BEATS = LB / BB;

    typedef struct {
        logic [1:0]   index;
        logic         way;
        logic [25:0]  tag;
        logic [127:0] data;
        logic         done;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_valid;
    logic [AW-1:0] miss_addr;
    logic          flush;
    logic          busy;
    logic          fill_done;

    icache_refill_ctrl_if #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .BEAT_BYTES(BB),
                            .SET_NUM(SN), .WAY_NUM(WN)) bus ();

    icache_refill_ctrl #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .BEAT_BYTES(BB),
                         .SET_NUM(SN), .WAY_NUM(WN)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .flush      (flush),
        .busy       (busy),
        .fill_done  (fill_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  passed = 0;
    int  victimModel = 0;
    wr_t expQ[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic monitor();
        wr_t e;
        if (bus.array_we && bus.array_valid) begin
            if (expQ.size() == 0) begin
                chk("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = expQ.pop_front();
                chk("wr_index", bus.array_index, e.index);
                chk("wr_way", bus.array_way, e.way);
                chk("wr_tag", bus.array_tag, e.tag);
                chk("wr_data", bus.array_data, e.data);
                chk("wr_fill_done", fill_done, e.done);
                $display("write idx=%0h way=%0d tag=%0h data=%032h done=%0b",
                         bus.array_index, bus.array_way, bus.array_tag, bus.array_data, fill_done);
            end
        end else if (fill_done) begin
            chk("stray_fill_done", fill_done, 1'b0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic initSweep();
        for (int e = 0; e < SN * WN; e++) begin
            chk("init_we", bus.array_we, 1'b1);
            chk("init_valid", bus.array_valid, 1'b0);
            chk("init_index", bus.array_index, e % SN);
            chk("init_way", bus.array_way, e / SN);
            chk("init_busy", busy, 1'b1);
            tick();
        end
        chk("init_done_busy", busy, 1'b0);
        chk("init_done_we", bus.array_we, 1'b0);
        $display("init sweep of %0d entries complete", SN * WN);
    endtask

    // One complete refill; flushWait/flushBeat < 0 means no flush in that phase.
    task automatic refill(input logic [31:0] addr, input int readyWait, input int flushWait,
                          input int flushBeat, input int gap, input logic [7:0] base);
        wr_t          e;
        logic [127:0] line;
        line = '0;
        for (int k = 0; k < BEATS; k++) line[k*32 +: 32] = 32'(base + k);
        e.index = addr[5:4];
        e.tag   = addr[31:6];
        e.way   = victimModel[0];
        e.data  = line;
        e.done  = (flushWait < 0) && (flushBeat < 0);
        expQ.push_back(e);
        victimModel = (victimModel + 1) % WN;

        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        miss_valid = 1'b0;
        miss_addr  = 32'hFFFF_FFFF;
        for (int i = 0; i < readyWait; i++) begin
            chk("req_valid_wait", bus.mem_req_valid, 1'b1);
            chk("req_addr_wait", bus.mem_req_addr, addr & 32'hFFFF_FFF0);
            flush = (i == flushWait);
            tick();
            flush = 1'b0;
        end
        bus.mem_req_ready = 1'b1;
        chk("req_valid", bus.mem_req_valid, 1'b1);
        chk("req_addr", bus.mem_req_addr, addr & 32'hFFFF_FFF0);
        tick();
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            for (int g = 0; g < gap; g++) tick();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = line[k*32 +: 32];
            flush = (k == flushBeat);
            tick();
            flush = 1'b0;
            bus.mem_rvalid = 1'b0;
        end
        chk("write_seen", expQ.size(), 0);
        chk("write_busy", busy, 1'b1);
        tick();
        chk("idle_busy", busy, 1'b0);
        $display("refill addr=%08h wait=%0d flushWait=%0d flushBeat=%0d gap=%0d",
                 addr, readyWait, flushWait, flushBeat, gap);
    endtask

    initial begin
        rst = 1'b1;
        miss_valid = 1'b0;
        miss_addr = '0;
        flush = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b1);
        chk("rst_fill_done", fill_done, 1'b0);
        chk("rst_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst_req_addr", bus.mem_req_addr, 0);
        chk("rst_tag", bus.array_tag, 0);
        chk("rst_data", bus.array_data, 0);
        $display("reset applied");
        rst = 1'b0;
        initSweep();

        // Same set twice: way 0 then way 1; second one waits 5 cycles with a flush.
        refill(32'h0000_1234, 0, -1, -1, 0, 8'hA0);
        refill(32'h0000_5234, 5, 2, -1, 0, 8'hB0);
        // Flush on beat 1 with gaps between beats.
        refill(32'h0000_0040, 0, -1, 1, 1, 8'hC0);

        // Miss coinciding with flush in IDLE is dropped.
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_0080;
        flush      = 1'b1;
        tick();
        miss_valid = 1'b0;
        flush      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("flush_miss_req", bus.mem_req_valid, 1'b0);
            chk("flush_miss_busy", busy, 1'b0);
            tick();
        end
        $display("miss with flush ignored");

        // Stray read beats in IDLE are ignored.
        bus.mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid = (i != 1);
            tick();
            chk("idle_rvalid_busy", busy, 1'b0);
            chk("idle_rvalid_we", bus.array_we, 1'b0);
        end
        bus.mem_rvalid = 1'b0;
        $display("idle read beats ignored");

        refill(32'hABCD_EF08, 0, -1, -1, 0, 8'h10);

        // Reset after two beats: no partial write, sweep restarts at entry 0.
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_00F0;
        tick();
        miss_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h5500 + k;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        victimModel = 0;
        initSweep();
        bus.mem_rvalid = 1'b0;
        $display("reset during fill recovered");

        refill(32'h0000_0F30, 1, -1, -1, 0, 8'h70);
        chk("queue_empty", expQ.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
